// File: rtl/reorder_buffer.sv
// Circular reorder buffer feeding the retire stage: in-order allocate, CDB writeback, head retire.
// Optional macro ROB_WB_BYPASS_EN forwards a same-cycle writeback to the head onto head_ready/head_value.
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = $clog2(DEPTH),
    parameter int REG_W  = 5,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              alloc_valid,
    input  logic [REG_W-1:0]  alloc_rd,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic [DATA_W-1:0] wb_value,
    output logic              head_valid,
    output logic              head_ready,
    output logic [REG_W-1:0]  head_rd,
    output logic [DATA_W-1:0] head_value,
    output logic [TAG_W-1:0]  head_tag,
    input  logic              rob_decrement,
    output logic [TAG_W:0]    count,
    output logic              empty,
    output logic              full
);

    localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  ready_q, ready_d;
    logic [REG_W-1:0]  rd_q    [DEPTH];
    logic [DATA_W-1:0] value_q [DEPTH];
    logic [TAG_W-1:0]  head_q, head_d;
    logic [TAG_W-1:0]  tail_q, tail_d;
    logic [TAG_W:0]    count_q, count_d;

    logic bypass_hit;
    logic alloc_fire;
    logic retire_fire;
    logic wb_fire;

    // Status flags come from the registered count only; a same-cycle retire never frees a slot early.
    assign full        = (count_q == DEPTH_CNT);
    assign empty       = (count_q == '0);
    assign alloc_ready = !full;
    assign alloc_tag   = tail_q;
    assign count       = count_q;
    assign head_tag    = head_q;
    assign head_valid  = valid_q[head_q];

`ifdef ROB_WB_BYPASS_EN
    assign bypass_hit = wb_valid && (wb_tag == head_q) && head_valid;
`else
    assign bypass_hit = 1'b0;
`endif

    assign head_ready = head_valid && (ready_q[head_q] || bypass_hit);
    assign head_rd    = head_valid ? rd_q[head_q] : '0;
    assign head_value = !head_valid ? '0 : (bypass_hit ? wb_value : value_q[head_q]);

    assign alloc_fire  = alloc_valid && !full && !flush;
    assign retire_fire = rob_decrement && head_ready && !flush;
    // A writeback racing the retire of its own entry is dropped with the entry.
    assign wb_fire     = wb_valid && valid_q[wb_tag] && !flush
                         && !(retire_fire && (wb_tag == head_q));

    // NOTE: combinational logic uses blocking '='; every output is defaulted first so no latch is inferred.
    always_comb begin
        valid_d = valid_q;
        ready_d = ready_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            valid_d = '0;
            ready_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wb_fire) begin
                ready_d[wb_tag] = 1'b1;
            end
            if (retire_fire) begin
                valid_d[head_q] = 1'b0;
                ready_d[head_q] = 1'b0;
                head_d          = head_q + TAG_W'(1);
            end
            if (alloc_fire) begin
                valid_d[tail_q] = 1'b1;
                ready_d[tail_q] = 1'b0;
                tail_d          = tail_q + TAG_W'(1);
            end
            unique case ({alloc_fire, retire_fire})
                2'b10:   count_d = count_q + (TAG_W+1)'(1);
                2'b01:   count_d = count_q - (TAG_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            ready_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            ready_q <= ready_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: payload storage has no reset; valid_q gates every read and allocation rewrites rd/value.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            rd_q[tail_q]    <= alloc_rd;
            value_q[tail_q] <= '0;
        end
        if (wb_fire) begin
            value_q[wb_tag] <= wb_value;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer (DEPTH=4): directed scenarios plus a queue-based random model.
module tb_reorder_buffer;

    localparam int DEPTH  = 4;
    localparam int TAG_W  = $clog2(DEPTH);
    localparam int REG_W  = 5;
    localparam int DATA_W = 64;

`ifdef ROB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              alloc_valid;
    logic [REG_W-1:0]  alloc_rd;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic              wb_valid;
    logic [TAG_W-1:0]  wb_tag;
    logic [DATA_W-1:0] wb_value;
    logic              head_valid;
    logic              head_ready;
    logic [REG_W-1:0]  head_rd;
    logic [DATA_W-1:0] head_value;
    logic [TAG_W-1:0]  head_tag;
    logic              rob_decrement;
    logic [TAG_W:0]    count;
    logic              empty;
    logic              full;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int                tag;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] val;
        bit                rdy;
    } ent_t;

    ent_t q[$];
    int   m_head;
    int   m_tail;

    always #5 clk = ~clk;

    reorder_buffer #(
        .DEPTH  (DEPTH),
        .REG_W  (REG_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .alloc_valid   (alloc_valid),
        .alloc_rd      (alloc_rd),
        .alloc_ready   (alloc_ready),
        .alloc_tag     (alloc_tag),
        .wb_valid      (wb_valid),
        .wb_tag        (wb_tag),
        .wb_value      (wb_value),
        .head_valid    (head_valid),
        .head_ready    (head_ready),
        .head_rd       (head_rd),
        .head_value    (head_value),
        .head_tag      (head_tag),
        .rob_decrement (rob_decrement),
        .count         (count),
        .empty         (empty),
        .full          (full)
    );

    // Inputs change just after the falling edge; #1 lets combinational outputs settle before sampling.
    task automatic set_in(input logic av, input logic [REG_W-1:0] ard, input logic wv,
                          input logic [TAG_W-1:0] wt, input logic [DATA_W-1:0] wd,
                          input logic dec, input logic fl);
        alloc_valid   = av;
        alloc_rd      = ard;
        wb_valid      = wv;
        wb_tag        = wt;
        wb_value      = wd;
        rob_decrement = dec;
        flush         = fl;
        #1;
    endtask

    task automatic idle();
        set_in(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({alloc_ready, alloc_tag, count, empty, full} !== {1'b1, 2'd0, 3'd0, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_status: got %b expected %b", {alloc_ready, alloc_tag, count, empty, full}, 8'b1_00_000_10);
        end
        n_checks++;
        if ({head_valid, head_ready, head_rd, head_value, head_tag} !== '0) begin
            n_errors++;
            $display("FAIL reset_head: got %h expected 0", {head_valid, head_ready, head_rd, head_value, head_tag});
        end
    endtask

    task automatic test_alloc_full();
        logic [REG_W-1:0] rds [4];
        rds = '{5'd3, 5'd7, 5'd9, 5'd1};
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, rds[i], 1'b0, '0, '0, 1'b0, 1'b0);
            n_checks++;
            if ({alloc_ready, alloc_tag} !== {1'b1, TAG_W'(i)}) begin
                n_errors++;
                $display("FAIL alloc_tag_%0d: got %b expected %b", i, {alloc_ready, alloc_tag}, {1'b1, TAG_W'(i)});
            end
            tick();
        end
        idle();
        n_checks++;
        if ({full, alloc_ready, count} !== {1'b1, 1'b0, 3'd4}) begin
            n_errors++;
            $display("FAIL full_flags: got %b expected %b", {full, alloc_ready, count}, 5'b10_100);
        end
        set_in(1'b1, 5'd5, 1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        idle();
        n_checks++;
        if ({count, alloc_tag, head_tag, head_rd, head_ready, head_value} !== {3'd4, 2'd0, 2'd0, 5'd3, 1'b0, 64'd0}) begin
            n_errors++;
            $display("FAIL alloc_when_full: got count=%0d tail=%0d head=%0d rd=%0d rdy=%b val=%h expected 4 0 0 3 0 0",
                     count, alloc_tag, head_tag, head_rd, head_ready, head_value);
        end
    endtask

    task automatic test_writeback_retire();
        set_in(1'b0, '0, 1'b1, 2'd1, 64'hAA, 1'b0, 1'b0);
        tick();
        set_in(1'b0, '0, 1'b1, 2'd0, 64'h55, 1'b0, 1'b0);
        n_checks++;
        if (head_ready !== BYP) begin
            n_errors++;
            $display("FAIL wb_head_same_cycle: got ready=%b expected %b", head_ready, BYP);
        end
        tick();
        set_in(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
        n_checks++;
        if ({head_ready, head_rd, head_value} !== {1'b1, 5'd3, 64'h55}) begin
            n_errors++;
            $display("FAIL retire_first: got rdy=%b rd=%0d val=%h expected 1 3 55", head_ready, head_rd, head_value);
        end
        tick();
        n_checks++;
        if ({head_tag, head_ready, head_rd, head_value} !== {2'd1, 1'b1, 5'd7, 64'hAA}) begin
            n_errors++;
            $display("FAIL retire_second: got tag=%0d rdy=%b rd=%0d val=%h expected 1 1 7 aa", head_tag, head_ready, head_rd, head_value);
        end
        tick();
        idle();
        n_checks++;
        if ({count, head_tag, head_rd, head_ready} !== {3'd2, 2'd2, 5'd9, 1'b0}) begin
            n_errors++;
            $display("FAIL after_retires: got count=%0d head=%0d rd=%0d rdy=%b expected 2 2 9 0", count, head_tag, head_rd, head_ready);
        end
    endtask

    task automatic test_full_wrap();
        set_in(1'b1, 5'd4, 1'b0, '0, '0, 1'b0, 1'b0);
        n_checks++;
        if (alloc_tag !== 2'd0) begin
            n_errors++;
            $display("FAIL tail_wrap: got %0d expected 0", alloc_tag);
        end
        tick();
        set_in(1'b1, 5'd6, 1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, '0, 1'b1, 2'd2, 64'h99, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 5'd8, 1'b0, '0, '0, 1'b1, 1'b0);
        n_checks++;
        if ({full, alloc_ready, head_ready} !== 3'b101) begin
            n_errors++;
            $display("FAIL full_before_retire: got %b expected 101", {full, alloc_ready, head_ready});
        end
        tick();
        set_in(1'b1, 5'd8, 1'b0, '0, '0, 1'b0, 1'b0);
        n_checks++;
        if ({count, head_tag, alloc_tag, head_rd, alloc_ready} !== {3'd3, 2'd3, 2'd2, 5'd1, 1'b1}) begin
            n_errors++;
            $display("FAIL retire_refuses_alloc: got count=%0d head=%0d tail=%0d rd=%0d ar=%b expected 3 3 2 1 1",
                     count, head_tag, alloc_tag, head_rd, alloc_ready);
        end
        tick();
        idle();
        n_checks++;
        if ({count, full, alloc_tag} !== {3'd4, 1'b1, 2'd3}) begin
            n_errors++;
            $display("FAIL refill: got count=%0d full=%b tail=%0d expected 4 1 3", count, full, alloc_tag);
        end
    endtask

    task automatic test_retire_not_ready();
        set_in(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        tick();
        idle();
        n_checks++;
        if ({count, head_tag, head_valid, head_ready} !== {3'd4, 2'd3, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL retire_not_ready: got count=%0d head=%0d v=%b r=%b expected 4 3 1 0", count, head_tag, head_valid, head_ready);
        end
        set_in(1'b0, '0, 1'b1, 2'd3, 64'h11, 1'b0, 1'b0);
        tick();
        set_in(1'b0, '0, 1'b1, 2'd3, 64'h22, 1'b0, 1'b0);
        tick();
        idle();
        n_checks++;
        if ({head_ready, head_value} !== {1'b1, 64'h22}) begin
            n_errors++;
            $display("FAIL wb_overwrite: got rdy=%b val=%h expected 1 22", head_ready, head_value);
        end
    endtask

    task automatic test_flush_and_ignored();
        set_in(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 5'd2, 1'b1, 2'd0, 64'hBEEF, 1'b1, 1'b1);
        n_checks++;
        if (count !== 3'd3) begin
            n_errors++;
            $display("FAIL pre_flush_count: got %0d expected 3", count);
        end
        tick();
        idle();
        n_checks++;
        if ({count, empty, full, head_tag, alloc_tag, head_valid, head_ready, alloc_ready} !== {3'd0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL flush_state: got %b expected 000100000001", {count, empty, full, head_tag, alloc_tag, head_valid, head_ready, alloc_ready});
        end
        set_in(1'b0, '0, 1'b1, 2'd2, 64'h5, 1'b1, 1'b0);
        tick();
        idle();
        n_checks++;
        if ({empty, count, head_ready, head_value} !== {1'b1, 3'd0, 1'b0, 64'd0}) begin
            n_errors++;
            $display("FAIL wb_when_empty: got empty=%b count=%0d rdy=%b val=%h expected 1 0 0 0", empty, count, head_ready, head_value);
        end
        set_in(1'b1, 5'd2, 1'b1, 2'd0, 64'hEE, 1'b0, 1'b0);
        tick();
        idle();
        n_checks++;
        if ({count, head_valid, head_ready, head_rd, head_value} !== {3'd1, 1'b1, 1'b0, 5'd2, 64'd0}) begin
            n_errors++;
            $display("FAIL wb_to_alloc_slot: got count=%0d v=%b r=%b rd=%0d val=%h expected 1 1 0 2 0",
                     count, head_valid, head_ready, head_rd, head_value);
        end
    endtask

    task automatic test_async_reset();
        set_in(1'b1, 5'd5, 1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        idle();
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({count, empty, full, alloc_ready, alloc_tag, head_tag, head_valid, head_ready, head_rd} !== {3'd0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0}) begin
            n_errors++;
            $display("FAIL async_reset: got %b", {count, empty, full, alloc_ready, alloc_tag, head_tag, head_valid, head_ready, head_rd});
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_bypass();
        set_in(1'b1, 5'd12, 1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, '0, 1'b1, 2'd0, 64'h1234, 1'b1, 1'b0);
        n_checks++;
        if ({head_ready, head_value} !== (BYP ? {1'b1, 64'h1234} : {1'b0, 64'd0})) begin
            n_errors++;
            $display("FAIL bypass_same_cycle: got rdy=%b val=%h bypass=%b", head_ready, head_value, BYP);
        end
        tick();
        if (!BYP) begin
            set_in(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
            n_checks++;
            if ({head_ready, head_value} !== {1'b1, 64'h1234}) begin
                n_errors++;
                $display("FAIL wb_next_cycle: got rdy=%b val=%h expected 1 1234", head_ready, head_value);
            end
            tick();
        end
        idle();
        n_checks++;
        if ({count, empty, head_tag} !== {3'd0, 1'b1, 2'd1}) begin
            n_errors++;
            $display("FAIL bypass_retired: got count=%0d empty=%b head=%0d expected 0 1 1", count, empty, head_tag);
        end
    endtask

    task automatic test_random();
        logic              av, wv, dec, fl, hit, e_hv, e_hr;
        logic [REG_W-1:0]  ard, e_rd;
        logic [TAG_W-1:0]  wt;
        logic [DATA_W-1:0] wd, e_val;
        logic [80:0]       got_v, exp_v;
        int                idx;
        ent_t              ne;

        set_in(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        q.delete();
        m_head = 0;
        m_tail = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            av  = ($urandom_range(0, 99) < 60);
            ard = REG_W'($urandom);
            wv  = ($urandom_range(0, 99) < 50);
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                wt = TAG_W'(q[$urandom_range(0, q.size() - 1)].tag);
            else
                wt = TAG_W'($urandom);
            wd  = {$urandom, $urandom};
            dec = ($urandom_range(0, 99) < 55);
            fl  = ($urandom_range(0, 99) < 2);
            set_in(av, ard, wv, wt, wd, dec, fl);

            e_hv  = (q.size() > 0);
            hit   = 1'b0;
            e_hr  = 1'b0;
            e_rd  = '0;
            e_val = '0;
            if (e_hv) begin
                hit   = BYP && wv && (int'(wt) == q[0].tag);
                e_hr  = q[0].rdy || hit;
                e_rd  = q[0].rd;
                e_val = hit ? wd : q[0].val;
            end
            exp_v = {(q.size() != DEPTH), TAG_W'(m_tail), e_hv, e_hr, e_rd, e_val, TAG_W'(m_head),
                     (TAG_W+1)'(q.size()), (q.size() == 0), (q.size() == DEPTH)};
            got_v = {alloc_ready, alloc_tag, head_valid, head_ready, head_rd, head_value, head_tag, count, empty, full};
            n_checks++;
            if (got_v !== exp_v) begin
                n_errors++;
                $display("FAIL random_cycle_%0d: got %h expected %h", cyc, got_v, exp_v);
            end

            if (fl) begin
                q.delete();
                m_head = 0;
                m_tail = 0;
            end else begin
                idx = -1;
                for (int k = 0; k < q.size(); k++)
                    if (q[k].tag == int'(wt)) idx = k;
                if (wv && idx >= 0 && !(dec && e_hr && idx == 0)) begin
                    q[idx].rdy = 1'b1;
                    q[idx].val = wd;
                end
                if (dec && e_hr) begin
                    void'(q.pop_front());
                    m_head = (m_head + 1) % DEPTH;
                end
                if (av && exp_v[80]) begin
                    ne.tag = m_tail;
                    ne.rd  = ard;
                    ne.val = '0;
                    ne.rdy = 1'b0;
                    q.push_back(ne);
                    m_tail = (m_tail + 1) % DEPTH;
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_alloc_full();
        test_writeback_retire();
        test_full_wrap();
        test_retire_not_ready();
        test_flush_and_ignored();
        test_async_reset();
        test_bypass();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
